// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S streamer: transmit modes and the
// occupancy counter width used by the frame FIFO and the top level.
package i2s_pkg;

    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_LJ  = 1'b1;

    // Occupancy must reach DEPTH itself, hence one bit more than the pointer.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO with show-ahead read data; pushes while full and
// pops while empty are dropped, pointers wrap modulo DEPTH.
module i2s_frame_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [WIDTH-1:0]          wdata_i,
    output logic [WIDTH-1:0]          rdata_o,
    output logic [level_w(DEPTH)-1:0] level_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push_s, do_pop_s;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == LW'(0));
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            level_d = level_q + LW'(1);
        end else if (do_pop_s && !do_push_s) begin
            level_d = level_q - LW'(1);
        end else begin
            level_d = level_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            level_q  <= LW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/i2s_streamer.sv
// Multi-lane I2S / left-justified transmitter: frames buffered in a FIFO,
// serialised MSB-first, with outputs changing only on SCLK falling events.
module i2s_streamer
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int LANES      = 4,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int SCLK_DIV   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           mode_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    input  logic [LANES*2*SAMPLE_W-1:0]    s_data_i,
    output logic                           sclk_o,
    output logic                           lrclk_o,
    output logic [LANES-1:0]               sd_o,
    output logic [level_w(FIFO_DEPTH)-1:0] level_o,
    output logic                           underrun_o
);

    localparam int FW       = LANES * 2 * SAMPLE_W;
    localparam int DW       = $clog2(SCLK_DIV);
    localparam int BW       = $clog2(2 * SLOT_W);
    localparam int LAST_BIT = 2 * SLOT_W - 1;

    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             sclk_q, sclk_d;
    logic             lrclk_q, lrclk_d;
    logic [LANES-1:0] sd_q, sd_d;
    logic             mode_q, mode_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic             underrun_q, underrun_d;
    logic             fall_s, wrap_s, pop_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [FW-1:0]    fifo_rdata_s, src_s;
    int               pos_s;

    // Bit at frame position pos (0 = left MSB) of one lane; slot padding is zero.
    function automatic logic frame_bit(input logic [FW-1:0] frame, input int lane, input int pos);
        logic [FW-1:0]       lane_bits;
        logic [SAMPLE_W-1:0] smp;
        int                  idx;
        lane_bits = frame >> (2 * SAMPLE_W * lane);
        idx       = pos % SLOT_W;
        if (pos >= SLOT_W) begin
            smp = lane_bits[SAMPLE_W-1:0];
        end else begin
            smp = lane_bits[2*SAMPLE_W-1:SAMPLE_W];
        end
        smp = smp << idx;
        if (idx < SAMPLE_W) begin
            return smp[SAMPLE_W-1];
        end else begin
            return 1'b0;
        end
    endfunction

    i2s_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (s_valid_i),
        .pop_i   (pop_s),
        .wdata_i (s_data_i),
        .rdata_o (fifo_rdata_s),
        .level_o (level_o),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign s_ready_o  = !fifo_full_s;
    assign sclk_o     = sclk_q;
    assign lrclk_o    = lrclk_q;
    assign sd_o       = sd_q;
    assign underrun_o = underrun_q;

    always_comb begin
        fall_s     = (div_q == DW'(SCLK_DIV - 1));
        wrap_s     = (bit_q == BW'(LAST_BIT));
        div_d      = fall_s ? DW'(0) : div_q + DW'(1);
        sclk_d     = (div_d >= DW'(SCLK_DIV / 2));
        bit_d      = bit_q;
        lrclk_d    = lrclk_q;
        sd_d       = sd_q;
        mode_d     = mode_q;
        frame_d    = frame_q;
        underrun_d = 1'b0;
        pop_s      = 1'b0;
        src_s      = frame_q;
        pos_s      = 0;
        if (fall_s) begin
            bit_d   = wrap_s ? BW'(0) : bit_q + BW'(1);
            lrclk_d = (bit_d >= BW'(SLOT_W));
            if (wrap_s) begin
                mode_d     = mode_i;
                pop_s      = !fifo_empty_s;
                underrun_d = fifo_empty_s;
                frame_d    = fifo_empty_s ? FW'(0) : fifo_rdata_s;
            end else begin
                mode_d = mode_q;
            end
            // I2S bit 0 still belongs to the outgoing frame's last bit.
            if (mode_d == MODE_LJ) begin
                src_s = frame_d;
                pos_s = int'(bit_d);
            end else if (bit_d == BW'(0)) begin
                src_s = frame_q;
                pos_s = LAST_BIT;
            end else begin
                src_s = frame_d;
                pos_s = int'(bit_d) - 1;
            end
            for (int l = 0; l < LANES; l++) begin
                sd_d[l] = frame_bit(src_s, l, pos_s);
            end
        end else begin
            bit_d = bit_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q      <= DW'(0);
            bit_q      <= BW'(0);
            sclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sd_q       <= LANES'(0);
            mode_q     <= MODE_I2S;
            frame_q    <= FW'(0);
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bit_q      <= bit_d;
            sclk_q     <= sclk_d;
            lrclk_q    <= lrclk_d;
            sd_q       <= sd_d;
            mode_q     <= mode_d;
            frame_q    <= frame_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_i2s_streamer.sv
// Directed bench for i2s_streamer: expected frames are queued as they are
// pushed and compared against captured serial lanes at each frame boundary.
module tb_i2s_streamer;
    import i2s_pkg::*;

    localparam int SW = 16;
    localparam int LN = 4;
    localparam int FD = 8;
    localparam int FW = LN * 2 * SW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mode = 1'b0;
    logic          s_valid = 1'b0;
    logic [FW-1:0] s_data = '0;
    logic          s_ready, sclk, lrclk, underrun;
    logic [LN-1:0] sd;
    logic [level_w(FD)-1:0] level;

    logic          ready6, sclk6, lrclk6, und6;
    logic [LN-1:0] sd6;
    logic [level_w(FD)-1:0] level6;

    always #5 clk = ~clk;

    i2s_streamer dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_data_i(s_data), .sclk_o(sclk), .lrclk_o(lrclk), .sd_o(sd), .level_o(level),
        .underrun_o(underrun)
    );

    i2s_streamer #(.SCLK_DIV(6)) dut6 (
        .clk_i(clk), .rst_i(rst), .mode_i(1'b0), .s_valid_i(1'b0), .s_ready_o(ready6),
        .s_data_i({FW{1'b0}}), .sclk_o(sclk6), .lrclk_o(lrclk6), .sd_o(sd6), .level_o(level6),
        .underrun_o(und6)
    );

    // Sink side: capture every lane on each SCLK rise, bit b at index b.
    logic [63:0] cap_sd [LN];
    logic [63:0] done_sd [LN];
    logic [63:0] cap_lr, done_lr;
    logic [5:0]  bitpos;
    int          frames_done;
    int          und_cnt = 0;

    always @(posedge sclk or posedge rst) begin
        if (rst) begin
            bitpos      <= 6'd0;
            frames_done <= 0;
        end else begin
            for (int l = 0; l < LN; l++) begin
                cap_sd[l][bitpos] <= sd[l];
                if (bitpos == 6'd63) done_sd[l] <= {sd[l], cap_sd[l][62:0]};
            end
            cap_lr[bitpos] <= lrclk;
            if (bitpos == 6'd63) begin
                done_lr     <= {lrclk, cap_lr[62:0]};
                frames_done <= frames_done + 1;
            end
            bitpos <= bitpos + 6'd1;
        end
    end

    always @(negedge clk) begin
        if (underrun) und_cnt <= und_cnt + 1;
    end

    int            n_vec = 0;
    int            n_err = 0;
    logic [FW-1:0] mq[$];
    logic [FW-1:0] cur_f, prev_f;
    logic          cur_mode;
    int            exp_und = 0;
    int            chk_frames = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serial stream of one lane as the sink sees it, index = bit number.
    function automatic logic [63:0] exp_stream(input logic [FW-1:0] f, input logic [FW-1:0] pf,
                                               input logic m, input int lane);
        logic [FW-1:0] t;
        logic [63:0]   seq, pseq, lj;
        t    = f >> (lane * 2 * SW);
        seq  = {t[2*SW-1:SW], 16'h0000, t[SW-1:0], 16'h0000};
        t    = pf >> (lane * 2 * SW);
        pseq = {t[2*SW-1:SW], 16'h0000, t[SW-1:0], 16'h0000};
        lj   = {<<{seq}};
        return (m == MODE_LJ) ? lj : {lj[62:0], pseq[0]};
    endfunction

    task automatic push(input logic [FW-1:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        chk("s_ready", 64'(s_ready), 64'(mq.size() < FD));
        if (mq.size() < FD) mq.push_back(d);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic step_frame(input string tag);
        int g = 0;
        while (frames_done <= chk_frames && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_seen"}, 64'(frames_done), 64'(chk_frames + 1));
        for (int l = 0; l < LN; l++) begin
            chk($sformatf("%s_lane%0d", tag, l), done_sd[l], exp_stream(cur_f, prev_f, cur_mode, l));
        end
        chk({tag, "_lrclk"}, done_lr, 64'hFFFF_FFFF_0000_0000);
        chk_frames++;
        repeat (4) @(negedge clk);
        prev_f   = cur_f;
        cur_mode = mode;
        if (mq.size() > 0) begin
            cur_f = mq.pop_front();
        end else begin
            cur_f = '0;
            exp_und++;
        end
        chk({tag, "_underrun"}, 64'(und_cnt), 64'(exp_und));
        chk({tag, "_level"}, 64'(level), 64'(mq.size()));
    endtask

    task automatic model_reset();
        mq.delete();
        cur_f      = '0;
        prev_f     = '0;
        cur_mode   = MODE_I2S;
        chk_frames = 0;
    endtask

    initial begin
        logic [FW-1:0] a_frame;
        int n, g;
        logic prev;
        a_frame = {LN{16'hA5F0, 16'h0F0F}};

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_lrclk", 64'(lrclk), 64'd0);
        chk("rst_sd", 64'(sd), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd1);
        model_reset();
        mode = MODE_I2S;
        rst  = 1'b0;

        push(a_frame);
        chk("level_one", 64'(level), 64'd1);
        step_frame("f0_zero");
        mode = MODE_LJ;
        push(a_frame);
        step_frame("f1_i2s");
        step_frame("f2_lj");
        mode = MODE_I2S;
        step_frame("f3_underrun");

        for (int i = 0; i < 9; i++) push({$urandom, $urandom, $urandom, $urandom});
        chk("full_ready", 64'(s_ready), 64'd0);
        chk("full_level", 64'(level), 64'd8);
        step_frame("f4_after_fill");
        step_frame("f5_rand");
        mode = MODE_LJ;
        step_frame("f6_rand");
        step_frame("f7_rand_lj");

        g = 0;
        while (bitpos != 6'd20 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("reach_bit20", 64'(bitpos), 64'd20);
        #2 rst = 1'b1;
        #1;
        chk("arst_sclk", 64'(sclk), 64'd0);
        chk("arst_lrclk", 64'(lrclk), 64'd0);
        chk("arst_sd", 64'(sd), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_ready", 64'(s_ready), 64'd1);
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
        push({$urandom, $urandom, $urandom, $urandom});
        step_frame("r0_zero");
        step_frame("r1_data");

        prev = sclk6;
        g = 0;
        while (!(sclk6 && !prev) && g < 20) begin
            prev = sclk6;
            @(negedge clk);
            g++;
        end
        n = 0;
        while (sclk6 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("div6_high", 64'(n), 64'd3);
        n = 0;
        while (!sclk6 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("div6_low", 64'(n), 64'd3);
        prev = lrclk6;
        g = 0;
        while (lrclk6 == prev && g < 1000) begin
            @(negedge clk);
            g++;
        end
        prev = lrclk6;
        n = 0;
        g = 0;
        while (lrclk6 == prev && g < 1000) begin
            @(negedge clk);
            if (sclk6 && (g % 6 == 0)) n = n;
            g++;
        end
        chk("div6_lr_period_clk", 64'(g), 64'd192);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
